fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h1C00_0000, PC value loaded at reset.
REQ-002 Parameter TIMEOUT, 15, max cycles WAIT holds imem_req without imem_ack (range 1..255).
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 fetch_en  input  1  fetch-stage enable strobe from the instruction controller (en bit 0).
REQ-006 pc_we  input  1  PC load strobe (branch/jump target from execute).
REQ-007 pc_next  input  32  PC load value.
REQ-008 imem_req  output  1  instruction memory request.
REQ-009 imem_addr  output  32  instruction memory word address.
REQ-010 imem_ack  input  1  memory response valid.
REQ-011 imem_rdata  input  32  memory response data.
REQ-012 inst  output  32  latched instruction word, stable until next completed fetch.
REQ-013 pc  output  32  current PC.
REQ-014 inst_valid  output  1  one-cycle pulse: inst updated this cycle.
REQ-015 busy  output  1  high while a fetch is outstanding.
REQ-016 fetch_err  output  1  sticky timeout flag.

Function
REQ-017 FSM states SHALL be IDLE, WAIT; encoding from the shared package.
REQ-018 IDLE + fetch_en: next cycle WAIT, imem_req=1, imem_addr=pc captured at the fetch_en edge; busy=1.
REQ-019 WAIT: imem_req and imem_addr held stable until imem_ack or timeout; fetch_en ignored.
REQ-020 WAIT + imem_ack: inst<=imem_rdata, inst_valid=1 for exactly one cycle (the cycle after ack), imem_req drops same edge, return to IDLE; min fetch latency fetch_en->inst_valid = 2 cycles with same-cycle ack.
REQ-021 On completed fetch, pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC->0) unless a PC load is pending or coincident.
REQ-022 pc_we in IDLE: pc<=pc_next next edge; pc_we coincident with fetch_en: fetch uses old pc, pc<=pc_next.
REQ-023 pc_we in WAIT: pc_next captured into a pending register (last write wins); applied instead of +4 when WAIT exits (ack or timeout).
REQ-024 imem_ack in IDLE SHALL be ignored.
REQ-025 pc_next[1:0] SHALL be forced to 2'b00 on load.

Reset
REQ-026 Reset (async assert, sync deassert usage): state=IDLE, pc=RESET_PC, inst=32'h0, inst_valid=0, imem_req=0, imem_addr=RESET_PC, busy=0, fetch_err=0, pending load cleared, timer cleared.
REQ-027 Reset during WAIT SHALL drop imem_req immediately; a late imem_ack after reset is ignored.

Configuration
REQ-028 Macro FETCH_TIMEOUT_EN defined: timer counts WAIT cycles; on reaching TIMEOUT without ack: imem_req drops, inst<=32'h0 (no-op, controller returns to idle), inst_valid pulses, pc unchanged (or pending load applied), fetch_err set until reset, state IDLE.
REQ-029 Macro undefined: WAIT held indefinitely, no timer logic, fetch_err tied 0.

Structure
REQ-030 Shared package cpu_pkg SHALL hold fetch_state_t enum, RESET_PC default constant, INST_NOP=32'h0.
REQ-031 Timeout counter SHALL be sub-module fetch_timer (clear, enable, terminal-count out), instantiated only under FETCH_TIMEOUT_EN.

Verification
REQ-032 Reset, fetch_en, ack same cycle as req with rdata=32'h0010_0C41 -> inst=32'h0010_0C41, inst_valid one pulse, pc=32'h1C00_0004.
REQ-033 fetch_en, ack after 5 cycles -> imem_addr stable 5 cycles, busy high throughout, second fetch_en in WAIT ignored.
REQ-034 pc_we=1 pc_next=32'h1C00_0100 during WAIT, then ack -> pc=32'h1C00_0100 (not +4).
REQ-035 pc=32'hFFFF_FFFC, completed fetch -> pc=32'h0000_0000.
REQ-036 FETCH_TIMEOUT_EN, no ack -> after 15 WAIT cycles imem_req=0, inst=32'h0, fetch_err=1, pc unchanged; stays 1 until rstn.
REQ-037 rstn low mid-WAIT, ack arrives after release -> imem_req=0, inst_valid stays 0, pc=RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM encoding, reset PC default, no-op word.
package cpu_pkg;

    typedef enum logic [0:0] {
        FETCH_IDLE = 1'b0,
        FETCH_WAIT = 1'b1
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C00_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0000;
    localparam int          TIMER_W          = 8;

    // Instruction addresses are word aligned; low two bits never reach the PC.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_timer.sv
// Wait-cycle counter for an outstanding fetch; tc_o flags the TIMEOUT-th enabled cycle.
module fetch_timer
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    assign tc_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch stage with PC tracking and branch-target capture.
// Optional fetch timeout watchdog is built when FETCH_TIMEOUT_EN is defined.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        fetch_en,
    input  logic        pc_we,
    input  logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        inst_valid,
    output logic        busy,
    output logic        fetch_err
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("fetch_unit: TIMEOUT must be within 1..255");
    end

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  inst_q, inst_d;
    logic         valid_q, valid_d;
    logic         pend_vld_q, pend_vld_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic         timeout_hit;
    logic         in_wait;

    assign in_wait = (state_q == FETCH_WAIT);

`ifdef FETCH_TIMEOUT_EN
    logic err_q;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_fetch_timer (
        .clk   (clk),
        .rstn  (rstn),
        .clr_i (!in_wait),
        .en_i  (in_wait),
        .tc_o  (timeout_hit)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if (in_wait && timeout_hit && !imem_ack) begin
            err_q <= 1'b1;
        end
    end

    assign fetch_err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign fetch_err   = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        inst_d     = inst_q;
        valid_d    = 1'b0;
        pend_vld_d = pend_vld_q;
        pend_pc_d  = pend_pc_q;

        case (state_q)
            FETCH_IDLE: begin
                if (pc_we) begin
                    pc_d = word_align(pc_next);
                end
                if (fetch_en) begin
                    state_d    = FETCH_WAIT;
                    addr_d     = pc_q;
                    // A target loaded alongside the fetch must not be overtaken by +4 at completion.
                    pend_vld_d = pc_we;
                    if (pc_we) begin
                        pend_pc_d = word_align(pc_next);
                    end
                end
            end
            FETCH_WAIT: begin
                if (imem_ack || timeout_hit) begin
                    state_d    = FETCH_IDLE;
                    valid_d    = 1'b1;
                    inst_d     = imem_ack ? imem_rdata : INST_NOP;
                    pend_vld_d = 1'b0;
                    if (pc_we) begin
                        pc_d = word_align(pc_next);
                    end else if (pend_vld_q) begin
                        pc_d = pend_pc_q;
                    end else if (imem_ack) begin
                        pc_d = pc_q + 32'd4;
                    end
                end else if (pc_we) begin
                    pend_vld_d = 1'b1;
                    pend_pc_d  = word_align(pc_next);
                end
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= FETCH_IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            inst_q     <= INST_NOP;
            valid_q    <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            inst_q     <= inst_d;
            valid_q    <= valid_d;
            pend_vld_q <= pend_vld_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

    assign imem_req   = in_wait;
    assign busy       = in_wait;
    assign imem_addr  = addr_q;
    assign inst       = inst_q;
    assign pc         = pc_q;
    assign inst_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, corner sequences, randomized run against a reference model.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h1C00_0000;
    localparam int          TMO = 15;
`ifdef FETCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        fetch_en, pc_we, imem_ack;
    logic [31:0] pc_next, imem_rdata;
    logic        imem_req, inst_valid, busy, fetch_err;
    logic [31:0] imem_addr, inst, pc;

    int total = 0;
    int bad   = 0;

    fetch_unit #(.RESET_PC(RPC), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .fetch_en   (fetch_en),
        .pc_we      (pc_we),
        .pc_next    (pc_next),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .pc         (pc),
        .inst_valid (inst_valid),
        .busy       (busy),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                             input logic [31:0] e_pc, input logic [31:0] e_inst,
                             input logic e_vld, input logic e_err);
        chk({tag, ".req"},  32'(imem_req),   32'(e_req));
        chk({tag, ".busy"}, 32'(busy),       32'(e_req));
        chk({tag, ".addr"}, imem_addr,       e_addr);
        chk({tag, ".pc"},   pc,              e_pc);
        chk({tag, ".inst"}, inst,            e_inst);
        chk({tag, ".vld"},  32'(inst_valid), 32'(e_vld));
        chk({tag, ".err"},  32'(fetch_err),  32'(e_err));
    endtask

    // Drive one cycle of inputs at the falling edge, then sample just after the rising edge.
    task automatic step(input logic fe, input logic we, input logic [31:0] nx,
                        input logic ack, input logic [31:0] rd);
        @(negedge clk);
        fetch_en   = fe;
        pc_we      = we;
        pc_next    = nx;
        imem_ack   = ack;
        imem_rdata = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; fetch_en = 1'b0; pc_we = 1'b0; pc_next = '0; imem_ack = 1'b0; imem_rdata = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    typedef struct {
        logic        fe;
        logic        we;
        logic [31:0] nx;
        logic        ack;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_vld;
    } vec_t;

    vec_t tbl[12];

    // Reference model: one fetch in flight at most, plus the branch target owed to its completion.
    bit          m_busy, m_vld, m_err, m_owed;
    logic [31:0] m_pc, m_addr, m_inst, m_target;
    int          m_waited;

    task automatic model_reset();
        m_busy = 0; m_vld = 0; m_err = 0; m_owed = 0;
        m_pc = RPC; m_addr = RPC; m_inst = 32'h0; m_target = 32'h0; m_waited = 0;
    endtask

    task automatic model_step(input logic fe, input logic we, input logic [31:0] nx,
                              input logic ack, input logic [31:0] rd);
        logic [31:0] tgt;
        bit          to;
        tgt   = {nx[31:2], 2'b00};
        m_vld = 0;
        if (!m_busy) begin
            if (fe) begin
                m_busy   = 1;
                m_addr   = m_pc;
                m_waited = 0;
                m_owed   = we;
                m_target = tgt;
            end
            if (we) m_pc = tgt;
        end else begin
            m_waited++;
            to = TO_EN && !ack && (m_waited >= TMO);
            if (ack || to) begin
                m_busy = 0;
                m_vld  = 1;
                m_inst = ack ? rd : 32'h0;
                if (to) m_err = 1;
                if (we)          m_pc = tgt;
                else if (m_owed) m_pc = m_target;
                else if (ack)    m_pc = m_pc + 32'd4;
                m_owed = 0;
            end else if (we) begin
                m_owed   = 1;
                m_target = tgt;
            end
        end
    endtask

    initial begin
        int n;
        int ack_pct;
        logic fe, we, ack;
        logic [31:0] nx, rd;

        tbl[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, RPC,           RPC,           32'h0,         1'b0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0010_0C41, 1'b0, RPC,           32'h1C00_0004, 32'h0010_0C41, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, RPC,           32'h1C00_0004, 32'h0010_0C41, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0, RPC,           32'hFFFF_FFFC, 32'h0010_0C41, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0010_0C41, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hA5A5_A5A5, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'hA5A5_A5A5, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 32'h0000_0203, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 32'h0000_0200, 32'hA5A5_A5A5, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h1111_1111, 1'b0, 32'h0000_0000, 32'h0000_0200, 32'h1111_1111, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h2222_2222, 1'b0, 32'h0000_0000, 32'h0000_0200, 32'h1111_1111, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0200, 32'h0000_0200, 32'h1111_1111, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 32'h1C00_0100, 1'b0, 32'h0,         1'b1, 32'h0000_0200, 32'h0000_0200, 32'h1111_1111, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h3333_3333, 1'b0, 32'h0000_0200, 32'h1C00_0100, 32'h3333_3333, 1'b1};

        rstn = 1'b0; fetch_en = 1'b0; pc_we = 1'b0; pc_next = '0; imem_ack = 1'b0; imem_rdata = '0;
        do_reset();
        #1;
        check_all("reset", 1'b0, RPC, RPC, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].fe, tbl[i].we, tbl[i].nx, tbl[i].ack, tbl[i].rd);
            check_all($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_pc, tbl[i].e_inst, tbl[i].e_vld, 1'b0);
        end

        // Slow ack with a repeated fetch_en that must not queue a second fetch.
        step(1, 0, 0, 0, 0);
        check_all("slow.start", 1'b1, 32'h1C00_0100, 32'h1C00_0100, 32'h3333_3333, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0, 0);
            check_all($sformatf("slow.hold%0d", i), 1'b1, 32'h1C00_0100, 32'h1C00_0100, 32'h3333_3333, 1'b0, 1'b0);
        end
        step(0, 0, 0, 1, 32'hCAFE_0001);
        check_all("slow.ack", 1'b0, 32'h1C00_0100, 32'h1C00_0104, 32'hCAFE_0001, 1'b1, 1'b0);
        step(0, 0, 0, 0, 0);
        check_all("slow.after", 1'b0, 32'h1C00_0100, 32'h1C00_0104, 32'hCAFE_0001, 1'b0, 1'b0);

        // Two loads during WAIT: the later one wins; then a load coincident with ack.
        step(1, 0, 0, 0, 0);
        step(0, 1, 32'h0000_4000, 0, 0);
        step(0, 1, 32'h0000_5006, 0, 0);
        step(0, 0, 0, 1, 32'h0000_0001);
        check_all("lastwin", 1'b0, 32'h1C00_0104, 32'h0000_5004, 32'h0000_0001, 1'b1, 1'b0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 32'h0000_6008, 1, 32'h0000_0002);
        check_all("coinc", 1'b0, 32'h0000_5004, 32'h0000_6008, 32'h0000_0002, 1'b1, 1'b0);

        // A fetch that never gets an ack.
        step(1, 0, 0, 0, 0);
        n = 1;
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 100; i++) begin
            step(0, 0, 0, 0, 0);
            if (imem_req) n++;
            else break;
        end
        chk("timeout.cycles", 32'(n), 32'(TMO));
        check_all("timeout.exit", 1'b0, 32'h0000_6008, 32'h0000_6008, 32'h0, 1'b1, 1'b1);
        repeat (3) step(0, 0, 0, 0, 0);
        check_all("timeout.sticky", 1'b0, 32'h0000_6008, 32'h0000_6008, 32'h0, 1'b0, 1'b1);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h0000_0003);
        check_all("timeout.next", 1'b0, 32'h0000_6008, 32'h0000_600C, 32'h0000_0003, 1'b1, 1'b1);
`else
        for (int i = 0; i < 40; i++) begin
            step(0, 0, 0, 0, 0);
            if (imem_req) n++;
        end
        chk("hold.cycles", 32'(n), 32'd41);
        check_all("hold.state", 1'b1, 32'h0000_6008, 32'h0000_6008, 32'h0000_0002, 1'b0, 1'b0);
        step(0, 0, 0, 1, 32'h0000_0003);
        check_all("hold.ack", 1'b0, 32'h0000_6008, 32'h0000_600C, 32'h0000_0003, 1'b1, 1'b0);
`endif

        // Reset in the middle of WAIT, with a late ack after release.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("midrst.pre_req", 32'(imem_req), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check_all("midrst.async", 1'b0, RPC, RPC, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        step(0, 0, 0, 1, 32'hDEAD_BEEF);
        check_all("midrst.lateack", 1'b0, RPC, RPC, 32'h0, 1'b0, 1'b0);
        step(0, 0, 0, 0, 0);
        check_all("midrst.after", 1'b0, RPC, RPC, 32'h0, 1'b0, 1'b0);

        // Randomized traffic against the model.
        do_reset();
        model_reset();
        ack_pct = 40;
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) ack_pct = ($urandom_range(0, 1) != 0) ? 40 : 3;
            fe  = ($urandom_range(0, 1) != 0);
            we  = ($urandom_range(0, 4) == 0);
            nx  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
            ack = ($urandom_range(0, 99) < ack_pct);
            rd  = $urandom;
            model_step(fe, we, nx, ack, rd);
            step(fe, we, nx, ack, rd);
            check_all($sformatf("rnd%0d", c), m_busy, m_addr, m_pc, m_inst, m_vld, m_err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
